// File: rtl/risc16_boot_loader.sv
// risc16_boot_loader: program-load front end for the RiSC-16 core.
// Takes a big-endian byte stream (16-bit word count, then the words), writes
// the words into CPU memory from address 0, zeroes the 16 registers, then runs
// the CPU for MAX_CYCLES cycles and halts it for good (until reset_n).
// Optional feature macro: CLEAR_MEM_EN. When it is defined, every memory word
// is zeroed after reset, before the byte stream is accepted.
module risc16_boot_loader #(
  parameter int ADDR_W     = 16,
  parameter int MAX_CYCLES = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              rf_we,
  output logic [3:0]        rf_addr,
  output logic [15:0]       rf_wdata,
  output logic              cpu_run,
  output logic              pc_clear,
  output logic [15:0]       cycle_cnt,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_CLR_RF  = 3'd4,
    S_RUN     = 3'd5,
    S_HALT    = 3'd6,
    S_MCLR    = 3'd7
  } state_e;

`ifdef CLEAR_MEM_EN
  localparam state_e RESET_STATE = S_MCLR;
`else
  localparam state_e RESET_STATE = S_IDLE;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [15:0]       CYC_LIMIT = 16'(MAX_CYCLES);

  state_e              state_q, state_d;
  logic [7:0]          hdr_hi_q, hdr_hi_d;
  logic [7:0]          word_hi_q, word_hi_d;
  logic [15:0]         words_left_q, words_left_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          rf_cnt_q, rf_cnt_d;
  logic [15:0]         cycle_q, cycle_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                accept;

  assign accept    = in_valid & in_ready;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rf_addr   = rf_cnt_q;
  assign rf_wdata  = 16'h0000;
  assign cycle_cnt = cycle_q;

  // State and datapath registers; memory write port is registered so a word
  // lands on mem_* the cycle after its low byte is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RESET_STATE;
      hdr_hi_q     <= '0;
      word_hi_q    <= '0;
      words_left_q <= '0;
      addr_q       <= '0;
      rf_cnt_q     <= '0;
      cycle_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      hdr_hi_q     <= hdr_hi_d;
      word_hi_q    <= word_hi_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      rf_cnt_q     <= rf_cnt_d;
      cycle_q      <= cycle_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next-state logic and per-state outputs.
  always_comb begin
    state_d      = state_q;
    hdr_hi_d     = hdr_hi_q;
    word_hi_d    = word_hi_q;
    words_left_d = words_left_q;
    addr_d       = addr_q;
    rf_cnt_d     = rf_cnt_q;
    cycle_d      = cycle_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    in_ready     = 1'b0;
    rf_we        = 1'b0;
    cpu_run      = 1'b0;
    pc_clear     = 1'b1;
    halted       = 1'b0;

    case (state_q)
      S_MCLR: begin
`ifdef CLEAR_MEM_EN
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = 16'h0000;
        addr_d      = addr_q + ADDR_ONE;
        if (addr_q == '1) begin
          addr_d  = '0;
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          hdr_hi_d = in_data;
          state_d  = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          if ({hdr_hi_q, in_data} == 16'h0000) begin
            state_d = S_CLR_RF;
          end else begin
            words_left_d = {hdr_hi_q, in_data};
            addr_d       = '0;
            state_d      = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        in_ready = 1'b1;
        if (accept) begin
          word_hi_d = in_data;
          state_d   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = addr_q;
          mem_wdata_d  = {word_hi_q, in_data};
          addr_d       = addr_q + ADDR_ONE;
          words_left_d = words_left_q - 16'd1;
          state_d      = (words_left_q == 16'd1) ? S_CLR_RF : S_DATA_HI;
        end
      end
      S_CLR_RF: begin
        // The final memory word is still on the bus during the first cycle
        // here; hold off register writes so mem_we and rf_we never overlap.
        if (!mem_we_q) begin
          rf_we    = 1'b1;
          rf_cnt_d = rf_cnt_q + 4'd1;
          if (rf_cnt_q == 4'd15) state_d = S_RUN;
        end
      end
      S_RUN: begin
        cpu_run  = 1'b1;
        pc_clear = 1'b0;
        cycle_d  = cycle_q + 16'd1;
        if (cycle_d == CYC_LIMIT) state_d = S_HALT;
      end
      S_HALT: begin
        halted   = 1'b1;
        pc_clear = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_risc16_boot_loader.sv
// Testbench for risc16_boot_loader: drives byte streams (fixed and random,
// with and without valid gaps), injects junk bytes after the load, and checks
// memory writes, register clears, run budget and handshake counts against a
// simple stream model.
module tb_risc16_boot_loader;

  localparam int AW    = 4;
  localparam int MAXC  = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          rf_we;
  logic [3:0]    rf_addr;
  logic [15:0]   rf_wdata;
  logic          cpu_run;
  logic          pc_clear;
  logic [15:0]   cycle_cnt;
  logic          halted;

  risc16_boot_loader #(.ADDR_W(AW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .cpu_run(cpu_run),
    .pc_clear(pc_clear), .cycle_cnt(cycle_cnt), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: the only writer of these logs; tests work on deltas.
  int            mon_cyc = 0;
  int            hs_cnt = 0;
  int            overlap_cnt = 0;
  int            run_cnt = 0;
  int            pcc_bad = 0;
  int            rf_nz = 0;
  int            last_mem_cyc = 0;
  int            run_rise_cyc = 0;
  logic          prev_run = 1'b0;
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];
  logic [3:0]    rf_addr_q[$];
  int            rf_cyc_q[$];

  always @(negedge clk) begin
    mon_cyc <= mon_cyc + 1;
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      last_mem_cyc <= mon_cyc;
    end
    if (rf_we) begin
      rf_addr_q.push_back(rf_addr);
      rf_cyc_q.push_back(mon_cyc);
      if (rf_wdata != 16'h0000) rf_nz <= rf_nz + 1;
    end
    if (mem_we && rf_we) overlap_cnt <= overlap_cnt + 1;
    if (cpu_run) run_cnt <= run_cnt + 1;
    if (cpu_run && !prev_run) run_rise_cyc <= mon_cyc;
    prev_run <= cpu_run;
    if (pc_clear !== !(cpu_run || halted)) pcc_bad <= pcc_bad + 1;
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
  end

  // Apply reset mid-cycle and check the immediate (asynchronous) reset state.
  task automatic do_reset();
    int base;
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_halted", halted, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_pc_clear", pc_clear, 1);
`ifdef CLEAR_MEM_EN
    check("rst_in_ready", in_ready, 0);
`else
    check("rst_in_ready", in_ready, 1);
`endif
    @(posedge clk);
    #1 check("rst_hold_mem_we", mem_we, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
`ifdef CLEAR_MEM_EN
    base = wr_addr_q.size();
    for (int i = 0; i < DEPTH + 8; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("mclr_done", in_ready, 1);
    @(negedge clk);
    check("mclr_count", wr_addr_q.size() - base, DEPTH);
    for (int i = 0; i < DEPTH && base + i < wr_addr_q.size(); i++) begin
      check("mclr_addr", wr_addr_q[base+i], i);
      check("mclr_data", wr_data_q[base+i], 0);
    end
    @(posedge clk);
    #1;
`else
    base = 0;
    #1;
`endif
  endtask

  // Present one byte until it is accepted (bounded); optional idle cycle first.
  task automatic send_byte(input logic [7:0] b, input bit gap, output bit ok);
    ok = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
  endtask

  // Full load of n words, then run to halt while throwing junk bytes at it.
  task automatic run_load(input int n, input logic [15:0] words[$], input bit gaps);
    logic [7:0] bytes[$];
    int wbase, rbase, hs0, ov0, run0, pcc0, nz0;
    bit ok;
    int ncmp;
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      bytes.push_back(words[i][15:8]);
      bytes.push_back(words[i][7:0]);
    end
    wbase = wr_addr_q.size();
    rbase = rf_addr_q.size();
    hs0 = hs_cnt; ov0 = overlap_cnt; run0 = run_cnt; pcc0 = pcc_bad; nz0 = rf_nz;
    foreach (bytes[i]) begin
      send_byte(bytes[i], gaps && (i % 2 == 1), ok);
      if (!ok) begin
        check("byte_accept_timeout", 0, 1);
        return;
      end
    end
    for (int t = 0; t < 300; t++) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      @(negedge clk);
      if (halted) break;
      @(posedge clk);
      #1;
    end
    check("halt_reached", halted, 1);
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1 in_valid = 1'b1;
      in_data = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("mem_wr_count", wr_addr_q.size() - wbase, n);
    ncmp = (wr_addr_q.size() - wbase < n) ? wr_addr_q.size() - wbase : n;
    for (int i = 0; i < ncmp; i++) begin
      check("mem_wr_addr", wr_addr_q[wbase+i], i % DEPTH);
      check("mem_wr_data", wr_data_q[wbase+i], words[i]);
    end
    check("rf_wr_count", rf_addr_q.size() - rbase, 16);
    for (int i = 0; i < 16 && rbase + i < rf_addr_q.size(); i++)
      check("rf_wr_addr", rf_addr_q[rbase+i], i);
    check("rf_wdata_zero", rf_nz - nz0, 0);
    if (n > 0 && rf_cyc_q.size() > rbase)
      check("mem_before_rf", last_mem_cyc < rf_cyc_q[rbase], 1);
    if (rf_cyc_q.size() >= rbase + 16)
      check("rf_before_run", rf_cyc_q[rbase+15] < run_rise_cyc, 1);
    check("handshakes", hs_cnt - hs0, 2 + 2 * n);
    check("mem_rf_overlap", overlap_cnt - ov0, 0);
    check("run_cycles", run_cnt - run0, MAXC);
    check("pc_clear_rule", pcc_bad - pcc0, 0);
    check("final_cycle_cnt", cycle_cnt, MAXC);
    check("final_halted", halted, 1);
    check("final_cpu_run", cpu_run, 0);
    check("final_in_ready", in_ready, 0);
    check("final_pc_clear", pc_clear, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w[$];
    int n, wb;
    bit ok;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2 reset_n = 1'b0;
    #20;

    // Fixed two-word load, back to back
    do_reset();
    w = {16'h1234, 16'hABCD};
    run_load(2, w, 1'b0);
    $display("load n=2 nogap done: checks=%0d errors=%0d", checks, errors);

    // Empty program
    do_reset();
    w = {};
    run_load(0, w, 1'b0);
    $display("load n=0 done: checks=%0d errors=%0d", checks, errors);

    // Same two words with valid gaps
    do_reset();
    w = {16'h1234, 16'hABCD};
    run_load(2, w, 1'b1);
    $display("load n=2 gaps done: checks=%0d errors=%0d", checks, errors);

    // Random loads, including counts past the memory depth (address wrap)
    for (int k = 0; k < 6; k++) begin
      do_reset();
      n = $urandom_range(1, DEPTH + 6);
      w = {};
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      run_load(n, w, 1'($urandom));
      $display("load n=%0d random done: checks=%0d errors=%0d", n, checks, errors);
    end

    // Reset in the middle of a load after three bytes
    do_reset();
    wb = wr_addr_q.size();
    send_byte(8'h00, 1'b0, ok);
    send_byte(8'h05, 1'b0, ok);
    send_byte(8'h7E, 1'b0, ok);
    check("abort_no_write", wr_addr_q.size() - wb, 0);
    do_reset();
    w = {16'hBEEF, 16'h0001, 16'hF00D};
    run_load(3, w, 1'b0);
    $display("abort then load n=3 done: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
